// File: rtl/parity_frame_rx.sv
// Framed serial byte receiver: start, 8 data bits LSB-first, parity, stop; valid/ready output.
// Optional build macro PARITY_RX_STRICT_EN enables two-sample start-bit qualification.
module parity_frame_rx #(
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_en,
  input  logic                 sdi,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 par_err,
  output logic                 frm_err,
  output logic                 overrun,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 err_clr
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   p_rx_q, p_rx_d;
  logic [7:0]             out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   par_err_q, par_err_d;
  logic                   frm_err_q, frm_err_d;
  logic                   overrun_q, overrun_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic complete, perr, ferr, load, drop, err_inc;
  logic odd;

  assign odd = (PARITY_ODD != 0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    p_rx_d   = p_rx_q;
    complete = 1'b0;
    if (bit_en) begin
      case (state_q)
        StIdle: begin
          if (!sdi) begin
`ifdef PARITY_RX_STRICT_EN
            state_d = StStart;
`else
            state_d = StData;
            cnt_d   = 3'd0;
`endif
          end
        end
        // Second start sample; a 1 here is treated as a glitch, not an error.
        StStart: begin
          if (!sdi) begin
            state_d = StData;
            cnt_d   = 3'd0;
          end else begin
            state_d = StIdle;
          end
        end
        StData: begin
          shift_d[cnt_q] = sdi;
          cnt_d          = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          p_rx_d  = sdi;
          state_d = StStop;
        end
        StStop: begin
          complete = 1'b1;
          state_d  = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign perr    = p_rx_q != ((^shift_q) ^ odd);
  assign ferr    = !sdi;
  assign load    = complete && (!out_valid_q || out_ready);
  assign drop    = complete && out_valid_q && !out_ready;
  // A dropped error frame still counts as a single event.
  assign err_inc = complete && (perr || ferr || drop);

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    par_err_d   = par_err_q;
    frm_err_d   = frm_err_q;
    overrun_d   = drop;
    err_cnt_d   = err_cnt_q;
    if (load) begin
      out_data_d  = shift_q;
      par_err_d   = perr;
      frm_err_d   = ferr;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (err_inc && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      shift_q     <= 8'h00;
      p_rx_q      <= 1'b0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      par_err_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      p_rx_q      <= p_rx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      par_err_q   <= par_err_d;
      frm_err_q   <= frm_err_d;
      overrun_q   <= overrun_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign par_err   = par_err_q;
  assign frm_err   = frm_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != StIdle);
  assign err_cnt   = err_cnt_q;

endmodule
